// File: rtl/accel_seq_if.sv
// SPI byte-engine handshake bundle between the accelerometer sequencer and the byte engine.
// Latency: none (wires only).
// Backpressure: the master holds req/rw/addr/wdata stable until the slave pulses ack.
//
// Ports: spi_req/spi_rw/spi_addr/spi_wdata driven by the master, spi_ack/spi_rdata by the slave.
interface accel_seq_if;
    logic       spi_req;
    logic       spi_rw;
    logic [5:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       spi_ack;
    logic [7:0] spi_rdata;

    modport master (
        output spi_req, spi_rw, spi_addr, spi_wdata,
        input  spi_ack, spi_rdata
    );

    modport slave (
        input  spi_req, spi_rw, spi_addr, spi_wdata,
        output spi_ack, spi_rdata
    );
endinterface

// File: rtl/accel_seq.sv
// Accelerometer sequencer: three init register writes, then periodic burst reads of X/Y(/Z).
// Latency: 4 (6 with Z) SPI read transactions + 1 PUBLISH cycle from sample tick to data_update.
// Backpressure: waits up to ACK_TIMEOUT cycles per spi_ack; ticks while busy collapse to one pending read.
//
// Ports: clk, reset (sync, active-high); spi (accel_seq_if.master) to the SPI byte engine;
//        data_x/data_y (and data_z) latest sample, data_update publish pulse, init_done level,
//        error pulse on ack timeout.
// Optional feature: define ACCEL_SEQ_Z_AXIS_EN to add data_z and extend the burst to 0x32..0x37.
module accel_seq #(
    parameter int unsigned UPDATE_DIV  = 25000,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    accel_seq_if.master  spi,
    output logic [15:0]  data_x,
    output logic [15:0]  data_y,
`ifdef ACCEL_SEQ_Z_AXIS_EN
    output logic [15:0]  data_z,
`endif
    output logic         data_update,
    output logic         init_done,
    output logic         error
);

`ifdef ACCEL_SEQ_Z_AXIS_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 4;
`endif
    localparam int         TW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [5:0] READ_BASE = 6'h32;
    localparam logic [2:0] LAST_IDX  = 3'(NBYTES - 1);

    typedef enum logic [2:0] {INIT0, INIT1, INIT2, IDLE, READ, PUBLISH} state_t;

    state_t                  state;
    logic [23:0]             tick_cnt;
    logic [TW-1:0]           to_cnt;
    logic                    pending;
    logic [2:0]              byte_idx;
    // Bytes shift in from the top so that after the last ack byte 0 sits in bits [7:0].
    logic [NBYTES*8-1:0]     shadow;

    logic                    tick;
    logic                    to_expire;
    logic [5:0]              init_addr;
    logic [7:0]              init_wdata;

    assign tick      = (tick_cnt == 24'(UPDATE_DIV - 1));
    // An ack in the same cycle as the last allowed wait cycle takes priority.
    assign to_expire = spi.spi_req && !spi.spi_ack && (to_cnt == TW'(ACK_TIMEOUT - 1));

    always_comb begin
        init_addr  = 6'h2C;
        init_wdata = 8'h0A;
        case (state)
            INIT1: begin
                init_addr  = 6'h31;
                init_wdata = 8'h0B;
            end
            INIT2: begin
                init_addr  = 6'h2D;
                init_wdata = 8'h08;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT0;
            spi.spi_req   <= 1'b0;
            spi.spi_rw    <= 1'b0;
            spi.spi_addr  <= 6'h00;
            spi.spi_wdata <= 8'h00;
            data_x        <= 16'h0000;
            data_y        <= 16'h0000;
`ifdef ACCEL_SEQ_Z_AXIS_EN
            data_z        <= 16'h0000;
`endif
            data_update   <= 1'b0;
            init_done     <= 1'b0;
            error         <= 1'b0;
            tick_cnt      <= '0;
            to_cnt        <= '0;
            pending       <= 1'b0;
            byte_idx      <= 3'd0;
            shadow        <= '0;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 24'd1;
            data_update <= 1'b0;
            error       <= 1'b0;

            // Counts cycles the current request has waited; idle whenever req is low.
            if (spi.spi_req && !spi.spi_ack)
                to_cnt <= to_cnt + TW'(1);
            else
                to_cnt <= '0;

            if (tick && state != IDLE)
                pending <= 1'b1;

            case (state)
                INIT0, INIT1, INIT2: begin
                    if (!spi.spi_req) begin
                        // Entering with req low guarantees the one-cycle gap between transactions.
                        spi.spi_req   <= 1'b1;
                        spi.spi_rw    <= 1'b0;
                        spi.spi_addr  <= init_addr;
                        spi.spi_wdata <= init_wdata;
                    end else if (spi.spi_ack) begin
                        spi.spi_req   <= 1'b0;
                        spi.spi_addr  <= 6'h00;
                        spi.spi_wdata <= 8'h00;
                        case (state)
                            INIT0:   state <= INIT1;
                            INIT1:   state <= INIT2;
                            default: begin
                                state     <= IDLE;
                                init_done <= 1'b1;
                            end
                        endcase
                    end else if (to_expire) begin
                        spi.spi_req   <= 1'b0;
                        spi.spi_addr  <= 6'h00;
                        spi.spi_wdata <= 8'h00;
                        error         <= 1'b1;
                        state         <= INIT0;
                    end
                end

                IDLE: begin
                    if (tick || pending) begin
                        state    <= READ;
                        byte_idx <= 3'd0;
                        pending  <= 1'b0;
                    end
                end

                READ: begin
                    if (!spi.spi_req) begin
                        spi.spi_req   <= 1'b1;
                        spi.spi_rw    <= 1'b1;
                        spi.spi_addr  <= READ_BASE + {3'b000, byte_idx};
                        spi.spi_wdata <= 8'h00;
                    end else if (spi.spi_ack) begin
                        spi.spi_req  <= 1'b0;
                        spi.spi_rw   <= 1'b0;
                        spi.spi_addr <= 6'h00;
                        shadow       <= {spi.spi_rdata, shadow[NBYTES*8-1:8]};
                        if (byte_idx == LAST_IDX)
                            state <= PUBLISH;
                        else
                            byte_idx <= byte_idx + 3'd1;
                    end else if (to_expire) begin
                        spi.spi_req  <= 1'b0;
                        spi.spi_rw   <= 1'b0;
                        spi.spi_addr <= 6'h00;
                        error        <= 1'b1;
                        shadow       <= '0;
                        state        <= IDLE;
                    end
                end

                PUBLISH: begin
                    // Only place the sample outputs change, so all axes move together.
                    data_x      <= shadow[15:0];
                    data_y      <= shadow[31:16];
`ifdef ACCEL_SEQ_Z_AXIS_EN
                    data_z      <= shadow[47:32];
`endif
                    data_update <= 1'b1;
                    state       <= IDLE;
                end

                default: state <= INIT0;
            endcase
        end
    end

endmodule
